// File: rtl/mux9_rr_arbiter.sv
// mux9_rr_arbiter
//   Round-robin arbiter and sequencer in front of a 9:1 data mux. Nine
//   requesters (a..i) share one valid/ready output channel. One requester is
//   granted at a time for a burst of up to MAX_BURST beats. After that, the
//   next requester in circular order after the last-served one wins.
//
// Ports
//   clk        clock, all state changes on posedge
//   reset      synchronous, active-high reset
//   req[8:0]   req[k]=1: requester k (0=a .. 8=i) has a beat pending
//   last_beat  the granted requester's current beat ends its burst
//   a..i       requester data words
//   out_ready  downstream accepts the beat this cycle
//   sel        registered mux select, 0..8 = a..i, 4'hF = idle
//   grant      one-hot registered grant, all zero when idle
//   ack        grant qualified by an accepted beat this cycle
//   out_valid  high while a requester is granted
//   out        word selected by sel, all ones when idle
module mux9_rr_arbiter #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [8:0]       req,
   input  logic             last_beat,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] f,
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] h,
   input  logic [WIDTH-1:0] i,
   input  logic             out_ready,
   output logic [3:0]       sel,
   output logic [8:0]       grant,
   output logic [8:0]       ack,
   output logic             out_valid,
   output logic [WIDTH-1:0] out
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t      state_q, state_d;
   logic [3:0]  sel_q, sel_d;
   logic [8:0]  grant_q, grant_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  ptr_q, ptr_d;

   logic        xfer;
   logic [3:0]  base;
   logic [3:0]  win;
   logic        win_found;
   logic [3:0]  idx;
   int unsigned sum;

   assign out_valid = (state_q == GRANT);
   assign xfer      = out_valid & out_ready;
   assign sel       = sel_q;
   assign grant     = grant_q;
   // A beat is not taken on a reset cycle: the edge discards it.
   assign ack       = grant_q & {9{xfer & ~reset}};

   // Circular search starting after base. When releasing, base is the current
   // owner. The owner is visited last, so it is only re-granted when nobody
   // else is requesting. In IDLE, base is the last-served index.
   always_comb begin
      base      = (state_q == GRANT) ? sel_q : ptr_q;
      win       = '0;
      win_found = 1'b0;
      sum       = 0;
      idx       = '0;
      for (int unsigned k = 1; k <= 9; k++) begin
         sum = 32'(base) + k;
         idx = (sum >= 9) ? 4'(sum - 9) : 4'(sum);
         if (!win_found && req[idx]) begin
            win       = idx;
            win_found = 1'b1;
         end
      end
   end

   always_comb begin
      logic rearb;
      state_d = state_q;
      sel_d   = sel_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      rearb   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) rearb = 1'b1;
         end
         GRANT: begin
            if (!xfer) begin
               if (!req[sel_q]) begin
                  ptr_d = sel_q;
                  rearb = 1'b1;
               end
            end else if (!last_beat && ((32'(cnt_q) + 32'd1) < MAX_BURST)) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               ptr_d = sel_q;
               rearb = 1'b1;
            end
         end
         default: ;
      endcase
      if (rearb) begin
         cnt_d = '0;
         if (win_found) begin
            state_d = GRANT;
            sel_d   = win;
            grant_d = 9'b1 << win;
         end else begin
            state_d = IDLE;
            sel_d   = '1;
            grant_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= '1;
         grant_q <= '0;
         cnt_q   <= '0;
         ptr_q   <= 4'd8;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      case (sel_q)
         4'd0:    out = a;
         4'd1:    out = b;
         4'd2:    out = c;
         4'd3:    out = d;
         4'd4:    out = e;
         4'd5:    out = f;
         4'd6:    out = g;
         4'd7:    out = h;
         4'd8:    out = i;
         default: out = '1;
      endcase
   end

endmodule

// File: tb/tb_mux9_rr_arbiter.sv
// Scoreboard bench for mux9_rr_arbiter. For each cycle, the driver computes the
// expected outputs from a behavioural owner/pointer model and queues them.
// The monitor pops the queued values on the falling edge and compares them.
module tb_mux9_rr_arbiter;

   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [8:0]  req;
   logic        last_beat;
   logic        out_ready;
   logic [15:0] dat [9];
   logic [3:0]  sel;
   logic [8:0]  grant;
   logic [8:0]  ack;
   logic        out_valid;
   logic [15:0] out;

   always #5 clk = ~clk;

   mux9_rr_arbiter #(.WIDTH(16), .MAX_BURST(MAXB)) dut (
      .clk(clk), .reset(reset), .req(req), .last_beat(last_beat),
      .a(dat[0]), .b(dat[1]), .c(dat[2]), .d(dat[3]), .e(dat[4]),
      .f(dat[5]), .g(dat[6]), .h(dat[7]), .i(dat[8]),
      .out_ready(out_ready), .sel(sel), .grant(grant), .ack(ack),
      .out_valid(out_valid), .out(out)
   );

   typedef struct packed {
      logic [3:0]  sel;
      logic [8:0]  grant;
      logic [8:0]  ack;
      logic        valid;
      logic [15:0] out;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   done     = 0;

   // Reference model: owner (-1 = nobody), last-served index, beats used in burst.
   int owner = -1;
   int last_served = 8;
   int beats = 0;

   function automatic int pick(input int after, input logic [8:0] r);
      for (int k = 1; k <= 9; k++) begin
         int n;
         n = (after + k) % 9;
         if (r[n]) return n;
      end
      return -1;
   endfunction

   task automatic step(input logic rst, input logic [8:0] rq,
                       input logic lb, input logic rdy);
      exp_t x;
      bit   release_now;
      reset = rst; req = rq; last_beat = lb; out_ready = rdy;
      if (owner < 0) begin
         x.sel = 4'hF; x.grant = '0; x.ack = '0; x.valid = 1'b0; x.out = 16'hFFFF;
      end else begin
         x.sel   = 4'(owner);
         x.grant = 9'(1 << owner);
         x.ack   = (rdy && !rst) ? 9'(1 << owner) : 9'h000;
         x.valid = 1'b1;
         x.out   = dat[owner];
      end
      exp_q.push_back(x);
      // advance the model to the state after this edge
      release_now = 0;
      if (rst) begin
         owner = -1; last_served = 8; beats = 0;
      end else if (owner < 0) begin
         owner = pick(last_served, rq); beats = 0;
      end else if (!rdy) begin
         if (!rq[owner]) release_now = 1;
      end else if (!lb && beats + 1 < MAXB) begin
         beats++;
      end else begin
         release_now = 1;
      end
      if (release_now) begin
         last_served = owner;
         owner = pick(last_served, rq);
         beats = 0;
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (sel !== e.sel || grant !== e.grant || ack !== e.ack ||
             out_valid !== e.valid || out !== e.out) begin
            failures++;
            $display("FAIL cycle_outputs t=%0t got sel=%h grant=%h ack=%h valid=%b out=%h expected sel=%h grant=%h ack=%h valid=%b out=%h",
                     $time, sel, grant, ack, out_valid, out,
                     e.sel, e.grant, e.ack, e.valid, e.out);
         end
      end else if (done) begin
         checks++;
         if (out_valid === 1'bx) begin
            failures++;
            $display("FAIL final_state got valid=%b expected 0 or 1", out_valid);
         end
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      reset = 1'b1; req = '0; last_beat = 1'b0; out_ready = 1'b0;
      for (int k = 0; k < 9; k++) dat[k] = 16'h000A + 16'(k);
      @(posedge clk);
      #1;
      // 1: idle after reset
      for (int n = 0; n < 20; n++) step(1'b0, 9'h000, 1'b0, 1'b0);
      // 2: everybody requests, one beat each
      for (int n = 0; n < 12; n++) step(1'b0, 9'h1FF, 1'b1, 1'b1);
      // 3: a and c alternate in bursts of MAX_BURST
      step(1'b1, 9'h000, 1'b0, 1'b0);
      for (int n = 0; n < 20; n++) step(1'b0, 9'h005, 1'b0, 1'b1);
      // 4: stall on e, then accept
      step(1'b1, 9'h000, 1'b0, 1'b0);
      for (int n = 0; n < 6; n++) step(1'b0, 9'h010, 1'b0, 1'b0);
      step(1'b0, 9'h010, 1'b0, 1'b1);
      step(1'b0, 9'h000, 1'b0, 1'b0);
      // 5: abort on h with and without i waiting
      step(1'b1, 9'h000, 1'b0, 1'b0);
      for (int n = 0; n < 2; n++) step(1'b0, 9'h080, 1'b0, 1'b0);
      step(1'b0, 9'h100, 1'b0, 1'b0);
      step(1'b0, 9'h100, 1'b1, 1'b1);
      for (int n = 0; n < 2; n++) step(1'b0, 9'h080, 1'b0, 1'b0);
      step(1'b0, 9'h000, 1'b0, 1'b0);
      step(1'b0, 9'h000, 1'b0, 1'b0);
      // 6: reset during 3rd beat, then lowest requesting index wins
      step(1'b0, 9'h1F0, 1'b0, 1'b1);
      step(1'b0, 9'h1F0, 1'b0, 1'b1);
      step(1'b0, 9'h1F0, 1'b0, 1'b1);
      step(1'b1, 9'h1F0, 1'b0, 1'b1);
      step(1'b0, 9'h0A4, 1'b0, 1'b1);
      step(1'b0, 9'h0A4, 1'b0, 1'b1);
      // randomized traffic
      begin
         logic [8:0] rq;
         rq = '0;
         for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 9'($urandom);
            if ($urandom_range(0, 2) == 0) dat[$urandom_range(0, 8)] = 16'($urandom);
            step(($urandom_range(0, 199) == 0), rq,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
         end
      end
      done = 1;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
